// File: rtl/periph_arb_pkg.sv
// periph_arb_pkg
//   Shared types and helpers for the peripheral initiator-side concentrator.
//   id_width(n) : bits needed to name one of n initiators, never below 1.
//   arb_id_t    : initiator index wide enough for the largest legal NB_MASTER (16).
package periph_arb_pkg;

    localparam int unsigned ARB_MAX_MASTER = 16;

    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned ARB_ID_W = id_width(ARB_MAX_MASTER);

    typedef logic [ARB_ID_W-1:0] arb_id_t;

endpackage

// File: rtl/periph_arb_id_fifo.sv
// periph_arb_id_fifo
//   DEPTH x WIDTH synchronous FIFO holding the initiator IDs of outstanding
//   transactions, oldest at the head.
//   Ports: clk, rst_ni (async, active low), push_i/din_i, pop_i/dout_o,
//          full_o, empty_o.
//   Push while full and pop while empty are ignored. Simultaneous push and
//   pop keep the occupancy unchanged. DEPTH=1 is supported.
module periph_arb_id_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push, w_pop;

    // With DEPTH=1 both pointers stay at 0.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    assign full_o  = (r_count == FULL_CNT);
    assign empty_o = (r_count == '0);
    assign w_push  = push_i & ~full_o;
    assign w_pop   = pop_i & ~empty_o;
    assign dout_o  = r_mem[r_rd_ptr];

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= din_i;
    end

endmodule

// File: rtl/periph_arb_mux.sv
// periph_arb_mux
//   N-to-1 concentrator on the cluster peripheral req/gnt/r_valid protocol.
//   Round-robin arbitration of NB_MASTER initiators onto one target port; the
//   IDs of granted requests are queued so each response returns to its issuer.
//   Initiator side : data_req_i/add/we_n/wdata/be (flat, master m at slice m),
//                    data_gnt_o, data_r_valid_o, broadcast r_rdata/r_opc.
//   Target side    : data_req_o/add/we_n/wdata/be, data_gnt_i,
//                    data_r_valid_i/r_rdata_i/r_opc_i.
//   resp_err_o     : sticky, a response arrived with nothing outstanding.
//   Optional (PERIPH_ARB_MUX_PERF_EN): contention_clr_i, contention_cnt_o,
//   a saturating count of cycles with contention or a full ID queue.
module periph_arb_mux
    import periph_arb_pkg::*;
#(
    parameter int unsigned NB_MASTER       = 4,
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned BE_WIDTH        = DATA_WIDTH / 8,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                             clk,
    input  logic                             rst_ni,
    input  logic [NB_MASTER-1:0]             data_req_i,
    input  logic [NB_MASTER*ADDR_WIDTH-1:0]  data_add_i,
    input  logic [NB_MASTER-1:0]             data_we_n_i,
    input  logic [NB_MASTER*DATA_WIDTH-1:0]  data_wdata_i,
    input  logic [NB_MASTER*BE_WIDTH-1:0]    data_be_i,
    output logic [NB_MASTER-1:0]             data_gnt_o,
    output logic [NB_MASTER-1:0]             data_r_valid_o,
    output logic [DATA_WIDTH-1:0]            data_r_rdata_o,
    output logic                             data_r_opc_o,
    output logic                             data_req_o,
    output logic [ADDR_WIDTH-1:0]            data_add_o,
    output logic                             data_we_n_o,
    output logic [DATA_WIDTH-1:0]            data_wdata_o,
    output logic [BE_WIDTH-1:0]              data_be_o,
    input  logic                             data_gnt_i,
    input  logic                             data_r_valid_i,
    input  logic [DATA_WIDTH-1:0]            data_r_rdata_i,
    input  logic                             data_r_opc_i,
`ifdef PERIPH_ARB_MUX_PERF_EN
    input  logic                             contention_clr_i,
    output logic [31:0]                      contention_cnt_o,
`endif
    output logic                             resp_err_o
);
    localparam int unsigned ID_WIDTH = id_width(NB_MASTER);
    localparam arb_id_t LAST_ID = arb_id_t'(NB_MASTER - 1);
    localparam logic [ARB_ID_W:0] NB_EXT = (ARB_ID_W + 1)'(NB_MASTER);

    arb_id_t               r_rr_ptr, r_winner_q;
    logic                  r_lock, r_resp_err;
    arb_id_t               w_rr_winner, w_winner, w_off, w_head;
    logic [NB_MASTER-1:0]  w_rot;
    logic [ARB_ID_W:0]     w_sum;
    logic                  w_lock_act, w_hs, w_pop, w_full, w_empty;
    logic [ID_WIDTH-1:0]   w_fifo_dout;

    // Rotate requests so bit 0 is the master at rr_ptr, take the lowest set
    // bit, then rotate the offset back into a master index.
    always_comb begin
        w_rot = (data_req_i >> r_rr_ptr) | (data_req_i << (NB_MASTER - r_rr_ptr));
        w_off = '0;
        for (int i = NB_MASTER - 1; i >= 0; i--) begin
            if (w_rot[i]) w_off = arb_id_t'(i);
        end
        w_sum = {1'b0, r_rr_ptr} + {1'b0, w_off};
        if (w_sum >= NB_EXT) w_sum = w_sum - NB_EXT;
        w_rr_winner = w_sum[ARB_ID_W-1:0];
    end

    // The lock only holds while the locked master keeps requesting, so a
    // dropped request releases the arbiter instead of wedging it.
    always_comb begin
        w_lock_act = 1'b0;
        for (int m = 0; m < NB_MASTER; m++) begin
            if (r_winner_q == arb_id_t'(m) && data_req_i[m]) w_lock_act = r_lock;
        end
        w_winner = w_lock_act ? r_winner_q : w_rr_winner;
    end

    assign data_req_o = rst_ni & (|data_req_i) & ~w_full;
    assign w_hs       = data_req_o & data_gnt_i;
    assign w_pop      = data_r_valid_i & ~w_empty;
    assign w_head     = arb_id_t'(w_fifo_dout);

    always_comb begin
        data_add_o   = '0;
        data_we_n_o  = 1'b1;
        data_wdata_o = '0;
        data_be_o    = '0;
        for (int m = 0; m < NB_MASTER; m++) begin
            data_gnt_o[m]     = w_hs & (w_winner == arb_id_t'(m));
            data_r_valid_o[m] = w_pop & (w_head == arb_id_t'(m));
            if (w_winner == arb_id_t'(m)) begin
                data_add_o   = data_add_i[m*ADDR_WIDTH +: ADDR_WIDTH];
                data_we_n_o  = data_we_n_i[m];
                data_wdata_o = data_wdata_i[m*DATA_WIDTH +: DATA_WIDTH];
                data_be_o    = data_be_i[m*BE_WIDTH +: BE_WIDTH];
            end
        end
    end

    assign data_r_rdata_o = data_r_rdata_i;
    assign data_r_opc_o   = data_r_opc_i;
    assign resp_err_o     = r_resp_err;

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rr_ptr   <= '0;
            r_lock     <= 1'b0;
            r_winner_q <= '0;
            r_resp_err <= 1'b0;
        end else begin
            if (w_hs) r_rr_ptr <= (w_winner == LAST_ID) ? '0 : w_winner + arb_id_t'(1);
            r_lock <= data_req_o & ~data_gnt_i;
            if (data_req_o & ~data_gnt_i) r_winner_q <= w_winner;
            if (data_r_valid_i & w_empty) r_resp_err <= 1'b1;
        end
    end

    periph_arb_id_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (ID_WIDTH)
    ) u_id_fifo (
        .clk     (clk),
        .rst_ni  (rst_ni),
        .push_i  (w_hs),
        .pop_i   (w_pop),
        .din_i   (w_winner[ID_WIDTH-1:0]),
        .dout_o  (w_fifo_dout),
        .full_o  (w_full),
        .empty_o (w_empty)
    );

`ifdef PERIPH_ARB_MUX_PERF_EN
    logic [31:0] r_cont_cnt;
    logic        w_contend;

    assign w_contend        = ($countones(data_req_i) >= 2) | ((|data_req_i) & w_full);
    assign contention_cnt_o = r_cont_cnt;

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni)                            r_cont_cnt <= '0;
        else if (contention_clr_i)              r_cont_cnt <= '0;
        else if (w_contend && r_cont_cnt != '1) r_cont_cnt <= r_cont_cnt + 32'd1;
    end
`endif

endmodule

// File: tb/tb_periph_arb_mux.sv
module tb_periph_arb_mux;
    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = 4;
    localparam int MO = 2;

    logic clk = 1'b0;
    logic rst_ni;
    always #5 clk = ~clk;

    logic [N-1:0]    data_req_i, data_we_n_i, data_gnt_o, data_r_valid_o;
    logic [N*AW-1:0] data_add_i;
    logic [N*DW-1:0] data_wdata_i;
    logic [N*BW-1:0] data_be_i;
    logic [DW-1:0]   data_r_rdata_o, data_wdata_o, data_r_rdata_i;
    logic [AW-1:0]   data_add_o;
    logic [BW-1:0]   data_be_o;
    logic            data_r_opc_o, data_req_o, data_we_n_o, data_gnt_i;
    logic            data_r_valid_i, data_r_opc_i, resp_err_o;
`ifdef PERIPH_ARB_MUX_PERF_EN
    logic            contention_clr_i = 1'b0;
    logic [31:0]     contention_cnt_o;
`endif

    periph_arb_mux #(.NB_MASTER(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                     .BE_WIDTH(BW), .MAX_OUTSTANDING(MO)) dut (
        .clk(clk), .rst_ni(rst_ni),
        .data_req_i(data_req_i), .data_add_i(data_add_i), .data_we_n_i(data_we_n_i),
        .data_wdata_i(data_wdata_i), .data_be_i(data_be_i),
        .data_gnt_o(data_gnt_o), .data_r_valid_o(data_r_valid_o),
        .data_r_rdata_o(data_r_rdata_o), .data_r_opc_o(data_r_opc_o),
        .data_req_o(data_req_o), .data_add_o(data_add_o), .data_we_n_o(data_we_n_o),
        .data_wdata_o(data_wdata_o), .data_be_o(data_be_o), .data_gnt_i(data_gnt_i),
        .data_r_valid_i(data_r_valid_i), .data_r_rdata_i(data_r_rdata_i),
        .data_r_opc_i(data_r_opc_i),
`ifdef PERIPH_ARB_MUX_PERF_EN
        .contention_clr_i(contention_clr_i), .contention_cnt_o(contention_cnt_o),
`endif
        .resp_err_o(resp_err_o));

    int n_chk = 0;
    int n_err = 0;

    // per-master stimulus
    bit            m_req [N];
    logic [AW-1:0] m_add [N];
    bit            m_we  [N];
    logic [DW-1:0] m_wd  [N];
    logic [BW-1:0] m_be  [N];

    // reference model: pointer, lock, queue of outstanding issuers, error flag
    int rr;
    bit lk;
    int lkw;
    int q[$];
    bit err;

    // observations captured by the last step, for directed checks
    logic [N-1:0]  o_gnt, o_rv;
    logic          o_req, o_opc;
    logic [AW-1:0] o_add;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        rr = 0; lk = 0; lkw = 0; err = 0;
        q.delete();
    endtask

    task automatic apply();
        for (int m = 0; m < N; m++) begin
            data_req_i[m]           = m_req[m];
            data_we_n_i[m]          = m_we[m];
            data_add_i[m*AW +: AW]  = m_add[m];
            data_wdata_i[m*DW +: DW] = m_wd[m];
            data_be_i[m*BW +: BW]   = m_be[m];
        end
    endtask

    function automatic int pick();
        if (lk && m_req[lkw]) return lkw;
        for (int i = 0; i < N; i++) begin
            int k = (rr + i) % N;
            if (m_req[k]) return k;
        end
        return 0;
    endfunction

    // Called #1 after a rising edge; checks mid-cycle, then advances the model
    // and returns #1 after the next rising edge.
    task automatic step();
        bit           any, ereq;
        int           w;
        logic [N-1:0] egnt, erv;
        apply();
        #3;
        any = 0;
        for (int m = 0; m < N; m++) any |= m_req[m];
        ereq = any && (q.size() < MO);
        w    = pick();
        egnt = (ereq && data_gnt_i) ? (N'(1) << w) : '0;
        erv  = (data_r_valid_i && q.size() > 0) ? (N'(1) << q[0]) : '0;
        o_gnt = data_gnt_o; o_rv = data_r_valid_o; o_req = data_req_o;
        o_add = data_add_o; o_opc = data_r_opc_o;
        chk("req_o", data_req_o, ereq);
        chk("gnt_o", data_gnt_o, egnt);
        if (ereq) begin
            chk("add_o", data_add_o, m_add[w]);
            chk("wfields_o", {data_we_n_o, data_be_o, data_wdata_o}, {m_we[w], m_be[w], m_wd[w]});
        end
        chk("r_valid_o", data_r_valid_o, erv);
        chk("r_rdata_o", data_r_rdata_o, data_r_rdata_i);
        chk("r_opc_o", data_r_opc_o, data_r_opc_i);
        chk("resp_err_o", resp_err_o, err);
        if (data_r_valid_i) begin
            if (q.size() > 0) void'(q.pop_front());
            else err = 1;
        end
        if (ereq && data_gnt_i) begin
            q.push_back(w);
            rr = (w + 1) % N;
            lk = 0;
        end else if (ereq) begin
            lk = 1; lkw = w;
        end else begin
            lk = 0;
        end
        @(posedge clk); #1;
    endtask

    task automatic clear_inputs();
        for (int m = 0; m < N; m++) begin
            m_req[m] = 0; m_add[m] = '0; m_we[m] = 1; m_wd[m] = '0; m_be[m] = '0;
        end
        data_gnt_i = 0; data_r_valid_i = 0; data_r_rdata_i = '0; data_r_opc_i = 0;
    endtask

    // asynchronous reset from mid-cycle; grants and responses must vanish at once
    task automatic do_reset();
        m_req[0] = 1; m_req[2] = 1;
        data_gnt_i = 1; data_r_valid_i = 1;
        apply();
        rst_ni = 0;
        #1;
        chk("rst_gnt_o", data_gnt_o, '0);
        chk("rst_r_valid_o", data_r_valid_o, '0);
        chk("rst_resp_err", resp_err_o, 1'b0);
        model_reset();
        clear_inputs();
        apply();
        @(posedge clk); #1;
        rst_ni = 1;
    endtask

    initial begin
        clear_inputs();
        apply();
        model_reset();
        rst_ni = 1;
        @(posedge clk); #1;
        do_reset();

        // two simultaneous requesters, pointer at 0
        m_req[0] = 1; m_add[0] = 32'h0000_1000;
        m_req[2] = 1; m_add[2] = 32'h0000_2000;
        data_gnt_i = 1;
        step(); chk("rr_cyc0", o_gnt, 4'b0001);
        m_req[0] = 0;
        step(); chk("rr_cyc1", o_gnt, 4'b0100);
        m_req[2] = 0;
        // queue is full now; responses return in issue order
        data_r_valid_i = 1; data_r_rdata_i = 32'hA5A5_0001;
        step(); chk("resp_first", o_rv, 4'b0001);
        data_r_rdata_i = 32'hA5A5_0003;
        step(); chk("resp_second", o_rv, 4'b0100);
        data_r_valid_i = 0;

        // lock: master 1 held off by the target for three cycles
        m_req[1] = 1; m_add[1] = 32'h1020_4000; data_gnt_i = 0;
        step(); chk("lock_add0", o_add, 32'h1020_4000);
        m_req[3] = 1; m_add[3] = 32'hDEAD_0000;
        step(); chk("lock_add1", o_add, 32'h1020_4000);
        step(); chk("lock_add2", o_add, 32'h1020_4000);
        data_gnt_i = 1;
        step(); chk("lock_gnt", o_gnt, 4'b0010);
        chk("lock_add3", o_add, 32'h1020_4000);
        m_req[1] = 0;
        step(); chk("after_lock_gnt", o_gnt, 4'b1000);
        m_req[3] = 0;
        // queue full: master 0 stalls, even in the cycle a response arrives
        m_req[0] = 1;
        step(); chk("full_stall", o_req, 1'b0);
        data_r_valid_i = 1; data_r_opc_i = 1;
        step(); chk("err_resp_rv", o_rv, 4'b0010);
        chk("err_resp_opc", o_opc, 1'b1);
        chk("no_bypass", o_req, 1'b0);
        data_r_opc_i = 0;
        step(); chk("pushpop_rv", o_rv, 4'b1000);
        chk("pushpop_gnt", o_gnt, 4'b0001);
        m_req[0] = 0;
        step(); chk("drain_rv", o_rv, 4'b0001);
        // stray response with nothing outstanding
        step(); chk("stray_rv", o_rv, 4'b0000);
        data_r_valid_i = 0;
        step(); chk("stray_err_set", resp_err_o, 1'b1);
        step(); chk("stray_err_sticky", resp_err_o, 1'b1);

        do_reset();

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) do_reset();
            for (int m = 0; m < N; m++) begin
                if (o_gnt[m] || !m_req[m]) begin
                    m_req[m] = ($urandom_range(99) < 35);
                    m_add[m] = $urandom; m_wd[m] = $urandom;
                    m_we[m]  = $urandom_range(1); m_be[m] = BW'($urandom);
                end else if ($urandom_range(99) < 4) begin
                    m_req[m] = 0;
                end
            end
            data_gnt_i     = ($urandom_range(99) < 60);
            data_r_valid_i = (q.size() > 0) ? ($urandom_range(99) < 50) : ($urandom_range(99) < 2);
            data_r_rdata_i = $urandom;
            data_r_opc_i   = ($urandom_range(99) < 10);
            o_gnt = '0;
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
